// File: rtl/data_mem_responder_if.sv
// Request/response bundle between a load/store initiator and the data memory.
// master drives request fields; slave returns ready, ack, load data and fault.
interface data_mem_responder_if;
  logic        i_req;
  logic        i_wr;
  logic [63:0] i_add;
  logic [63:0] i_dataWr;
  logic        o_ready;
  logic        o_ack;
  logic [63:0] o_dataRd;
  logic        o_err;

  modport master (
    output i_req, i_wr, i_add, i_dataWr,
    input  o_ready, o_ack, o_dataRd, o_err
  );

  modport slave (
    input  i_req, i_wr, i_add, i_dataWr,
    output o_ready, o_ack, o_dataRd, o_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Doubleword data memory with fixed wait states and a one-cycle ack.
// Ports: i_clk, i_rst_n (sync, active-low), bus (slave side of the if).
module data_mem_responder #(
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 2
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  data_mem_responder_if.slave  bus
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        wr_q;
  logic [63:0] add_q;
  logic [63:0] wdata_q;
  logic        ready_q;
  logic        ack_q;
  logic        err_q;
  logic [63:0] rd_q;
  logic [63:0] mem [DEPTH];

  function automatic logic fault(input logic [63:0] a);
    return (a[2:0] != 3'd0) || (a[63:3] >= 61'(DEPTH));
  endfunction

  function automatic logic [IW-1:0] idx(input logic [63:0] a);
    return a[3 +: IW];
  endfunction

  logic        cur_fault;
  logic [63:0] cur_rd;
  logic        new_fault;
  logic [63:0] new_rd;

  assign cur_fault = fault(add_q);
  assign cur_rd    = cur_fault ? 64'd0 : mem[idx(add_q)];
  // Zero-wait path responds straight from the live request fields.
  assign new_fault = fault(bus.i_add);
  assign new_rd    = new_fault ? 64'd0 : mem[idx(bus.i_add)];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      wr_q    <= 1'b0;
      add_q   <= 64'd0;
      wdata_q <= 64'd0;
      ready_q <= 1'b1;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 64'd0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= 64'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.i_req) begin
            wr_q    <= bus.i_wr;
            add_q   <= bus.i_add;
            wdata_q <= bus.i_dataWr;
            ready_q <= 1'b0;
            if (WAIT_CYCLES > 0) begin
              state <= WAIT;
              cnt   <= 4'(WAIT_CYCLES);
            end else begin
              state <= RESP;
              ack_q <= 1'b1;
              err_q <= new_fault;
              if (!bus.i_wr)
                rd_q <= new_rd;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= RESP;
            ack_q <= 1'b1;
            err_q <= cur_fault;
            if (!wr_q)
              rd_q <= cur_rd;
          end
        end
        RESP: begin
          state   <= IDLE;
          ack_q   <= 1'b0;
          ready_q <= 1'b1;
          // Store commits on leaving RESP so a reset in flight drops it.
          if (wr_q && !err_q)
            mem[idx(add_q)] <= wdata_q;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_ready  = ready_q;
  assign bus.o_ack    = ack_q;
  assign bus.o_dataRd = rd_q;
  assign bus.o_err    = err_q;

endmodule
